// File: rtl/aes_round_ctrl.sv
// AES-128 encryption round controller: holds state, round key and round counter,
// and drives an external combinational round datapath and key expander.
`timescale 1ns/1ps

module aes_round_ctrl #(
  parameter int unsigned Nb = 128,
  parameter int unsigned NR = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [Nb-1:0] plaintext,
  input  logic [Nb-1:0] key,
  output logic [Nb-1:0] dp_state_out,
  output logic [Nb-1:0] dp_key_out,
  output logic [7:0]    dp_rcon,
  output logic          dp_final,
  input  logic [Nb-1:0] dp_state_in,
  input  logic [Nb-1:0] dp_key_in,
  output logic [3:0]    round_cnt,
  output logic          busy,
  output logic          done,
  output logic [Nb-1:0] ciphertext
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ROUND = 2'd1;
  localparam logic [1:0] FINAL = 2'd2;

  localparam logic [3:0] RoundBeforeFinal = 4'(NR - 1);

  logic [1:0]    fsm_q, fsm_d;
  logic [Nb-1:0] state_q, state_d;
  logic [Nb-1:0] key_q, key_d;
  logic [Nb-1:0] ct_q, ct_d;
  logic [3:0]    rc_q, rc_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    key_d   = key_q;
    ct_d    = ct_q;
    rc_d    = rc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          // Initial AddRoundKey happens here, so round 1 sees the whitened block.
          state_d = plaintext ^ key;
          key_d   = key;
          rc_d    = 4'd1;
          busy_d  = 1'b1;
          fsm_d   = (NR == 1) ? FINAL : ROUND;
        end
      end

      ROUND: begin
        state_d = dp_state_in;
        key_d   = dp_key_in;
        rc_d    = rc_q + 4'd1;
        if (rc_q == RoundBeforeFinal) begin
          fsm_d = FINAL;
        end
      end

      FINAL: begin
        // State and key registers hold; only the ciphertext captures the last round.
        ct_d   = dp_state_in;
        done_d = 1'b1;
        busy_d = 1'b0;
        rc_d   = 4'd0;
        fsm_d  = IDLE;
      end

      default: begin
        fsm_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      rc_q    <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      rc_q    <= rc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    dp_rcon = 8'h00;
    case (rc_q)
      4'd1:    dp_rcon = 8'h01;
      4'd2:    dp_rcon = 8'h02;
      4'd3:    dp_rcon = 8'h04;
      4'd4:    dp_rcon = 8'h08;
      4'd5:    dp_rcon = 8'h10;
      4'd6:    dp_rcon = 8'h20;
      4'd7:    dp_rcon = 8'h40;
      4'd8:    dp_rcon = 8'h80;
      4'd9:    dp_rcon = 8'h1b;
      4'd10:   dp_rcon = 8'h36;
      default: dp_rcon = 8'h00;
    endcase
  end

  assign dp_final     = (fsm_q == FINAL);
  assign dp_state_out = state_q;
  assign dp_key_out   = key_q;
  assign round_cnt    = rc_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign ciphertext   = ct_q;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES-128 round and key
// expansion model closing the dp_* loop.
`timescale 1ns/1ps

module tb_aes_round_ctrl;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic [127:0] dp_state_out;
  logic [127:0] dp_key_out;
  logic [7:0]   dp_rcon;
  logic         dp_final;
  logic [127:0] dp_state_in;
  logic [127:0] dp_key_in;
  logic [3:0]   round_cnt;
  logic         busy;
  logic         done;
  logic [127:0] ciphertext;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [127:0] BPt  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BKey = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BR1  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] BCt  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] CPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CR1  = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] CCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  aes_round_ctrl #(
    .Nb (128),
    .NR (10)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .plaintext    (plaintext),
    .key          (key),
    .dp_state_out (dp_state_out),
    .dp_key_out   (dp_key_out),
    .dp_rcon      (dp_rcon),
    .dp_final     (dp_final),
    .dp_state_in  (dp_state_in),
    .dp_key_in    (dp_key_in),
    .round_cnt    (round_cnt),
    .busy         (busy),
    .done         (done),
    .ciphertext   (ciphertext)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: x^254 in GF(2^8) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      inv = gmul(inv, inv);
      if (i != 0) inv = gmul(inv, x);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m0, m1, m2, m3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++) begin
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    end
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        m0 = b[4*c];
        m1 = b[4*c+1];
        m2 = b[4*c+2];
        m3 = b[4*c+3];
        b[4*c]   = xtime(m0) ^ xtime(m1) ^ m1 ^ m2 ^ m3;
        b[4*c+1] = m0 ^ xtime(m1) ^ xtime(m2) ^ m2 ^ m3;
        b[4*c+2] = m0 ^ m1 ^ xtime(m2) ^ xtime(m3) ^ m3;
        b[4*c+3] = xtime(m0) ^ m0 ^ m1 ^ m2 ^ xtime(m3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ rk;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rcon);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rcon, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [7:0] rcon_exp(input int r);
    case (r)
      1:       return 8'h01;
      2:       return 8'h02;
      3:       return 8'h04;
      4:       return 8'h08;
      5:       return 8'h10;
      6:       return 8'h20;
      7:       return 8'h40;
      8:       return 8'h80;
      9:       return 8'h1b;
      10:      return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  assign dp_key_in   = key_expand(dp_key_out, dp_rcon);
  assign dp_state_in = aes_round(dp_state_out, dp_key_in, dp_final);

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " state"}, dp_state_out, 128'h0);
    check_eq({tag, " key"}, dp_key_out, 128'h0);
    check_eq({tag, " ct"}, ciphertext, 128'h0);
    check_eq({tag, " round"}, 128'(round_cnt), 128'h0);
    check_eq({tag, " busy"}, 128'(busy), 128'h0);
    check_eq({tag, " done"}, 128'(done), 128'h0);
    check_eq({tag, " rcon"}, 128'(dp_rcon), 128'h0);
    check_eq({tag, " final"}, 128'(dp_final), 128'h0);
  endtask

  // One encryption; inputs are scrambled right after acceptance.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                           input logic [127:0] exp_r1, input logic [127:0] exp_ct,
                           input logic [127:0] prev_ct);
    plaintext = pt;
    key       = k;
    start     = 1'b1;
    step();
    start     = 1'b0;
    plaintext = ~pt;
    key       = ~k;
    check_eq({tag, " r1 state"}, dp_state_out, exp_r1);
    check_eq({tag, " r1 key"}, dp_key_out, k);
    for (int r = 1; r <= 10; r++) begin
      check_eq($sformatf("%s round r%0d", tag, r), 128'(round_cnt), 128'(r));
      check_eq($sformatf("%s rcon r%0d", tag, r), 128'(dp_rcon), 128'(rcon_exp(r)));
      check_eq($sformatf("%s final r%0d", tag, r), 128'(dp_final), 128'(r == 10));
      check_eq($sformatf("%s done r%0d", tag, r), 128'(done), 128'h0);
      check_eq($sformatf("%s busy r%0d", tag, r), 128'(busy), 128'h1);
      check_eq($sformatf("%s ct hold r%0d", tag, r), ciphertext, prev_ct);
      step();
    end
    check_eq({tag, " done"}, 128'(done), 128'h1);
    check_eq({tag, " busy off"}, 128'(busy), 128'h0);
    check_eq({tag, " round 0"}, 128'(round_cnt), 128'h0);
    check_eq({tag, " ct"}, ciphertext, exp_ct);
    step();
    check_eq({tag, " done pulse"}, 128'(done), 128'h0);
    check_eq({tag, " ct stable"}, ciphertext, exp_ct);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b1;
    start     = 1'b0;
    plaintext = '0;
    key       = '0;
    #1 rst_n  = 1'b0;
    #1;
    check_all_zero("reset");
    step();
    step();
    rst_n = 1'b1;

    run_block("appB", BPt, BKey, BR1, BCt, 128'h0);
    run_block("c1", CPt, CKey, CR1, CCt, BCt);

    // start held high: one accepted block every 11 cycles, extra starts ignored.
    plaintext = CPt;
    key       = CKey;
    start     = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      check_eq($sformatf("hold done k%0d", k), 128'(done), 128'(k % 11 == 0));
      check_eq($sformatf("hold busy k%0d", k), 128'(busy), 128'(k % 11 != 0));
      check_eq($sformatf("hold round k%0d", k), 128'(round_cnt), 128'(k % 11));
      if (k % 11 == 0) check_eq($sformatf("hold ct k%0d", k), ciphertext, CCt);
    end
    start = 1'b0;
    repeat (4) step();
    check_eq("hold tail done", 128'(done), 128'h1);
    step();
    check_eq("hold tail idle", 128'(busy), 128'h0);

    // Reset in round 5: asynchronous clear, no done, then a clean restart.
    plaintext = CPt;
    key       = CKey;
    start     = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    check_eq("abort at r5", 128'(round_cnt), 128'h5);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async rst");
    step();
    check_eq("rst no done a", 128'(done), 128'h0);
    step();
    check_eq("rst no done b", 128'(done), 128'h0);
    rst_n = 1'b1;
    check_eq("rst ct zero", ciphertext, 128'h0);
    run_block("post rst", CPt, CKey, CR1, CCt, 128'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
